// File: rtl/fetch_queue.sv
// Instruction fetch queue: compacts up to NR_IN valid fetch slots per cycle into a
// circular buffer and hands them to decode one per cycle over valid/ready.

package tortoise_pkg;
  localparam int unsigned IFQ_DEPTH       = 8;
  localparam int unsigned INSTR_PER_FETCH = 2;

  typedef struct packed {
    logic       valid;
    logic [3:0] cause;
  } exception_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } predict_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] instr;
    exception_t  ex;
    predict_t    predict;
  } fetch_entry_t;
endpackage

module fetch_queue
  import tortoise_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH,
  parameter int unsigned NR_IN = INSTR_PER_FETCH
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  fetch_entry_t [NR_IN-1:0]     fetch_entry_i,
  output logic                         fetch_ready_o,
  output fetch_entry_t                 decode_entry_o,
  output logic                         decode_valid_o,
  input  logic                         decode_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;

  logic [PTR_W-1:0] widx [NR_IN];
  logic [CNT_W-1:0] n_push;
  logic [CNT_W-1:0] count_next;
  logic             push;
  logic             pop;

  // Each valid slot lands at wptr plus the number of valid slots below it.
  always_comb begin
    n_push = '0;
    for (int k = 0; k < NR_IN; k++) begin
      widx[k] = wptr + PTR_W'(n_push);
      if (fetch_entry_i[k].valid) n_push = n_push + CNT_W'(1);
    end
  end

  assign fetch_ready_o  = count <= CNT_W'(DEPTH - NR_IN);
  assign decode_valid_o = count != '0;
  assign count_o        = count;
  assign push           = fetch_ready_o && !flush_i;
  assign pop            = decode_valid_o && decode_ready_i && !flush_i;
  assign count_next     = count + (push ? n_push : CNT_W'(0)) - CNT_W'(pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(n_push);
      if (pop)  rptr <= rptr + PTR_W'(1);
      count <= count_next;
    end
  end

  // Storage is never cleared; stale contents are masked by count.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      for (int k = 0; k < NR_IN; k++) begin
        if (fetch_entry_i[k].valid) mem[widx[k]] <= fetch_entry_i[k];
      end
    end
  end

  always_comb begin
    decode_entry_o = '0;
    if (decode_valid_o) begin
      decode_entry_o       = mem[rptr];
      decode_entry_o.valid = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      a_count_bound : assert (count <= CNT_W'(DEPTH));
      a_ptr_count   : assert ((wptr - rptr) == PTR_W'(count));
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a driver pushes expected entries into a queue,
// a negedge monitor compares the presented head and status against it.

module tb_fetch_queue;
  import tortoise_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned NR_IN = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     flush = 1'b0;
  logic                     decode_ready = 1'b0;
  logic                     fetch_ready;
  logic                     decode_valid;
  fetch_entry_t [NR_IN-1:0] fetch_entry = '0;
  fetch_entry_t             decode_entry;
  logic [3:0]               count;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .NR_IN(NR_IN)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .fetch_entry_i  (fetch_entry),
    .fetch_ready_o  (fetch_ready),
    .decode_entry_o (decode_entry),
    .decode_valid_o (decode_valid),
    .decode_ready_i (decode_ready),
    .count_o        (count)
  );

  fetch_entry_t exp_q[$];
  int           mcount    = 0;
  int           cur_count = 0;
  logic [31:0]  next_addr = 32'h0;
  int           n_checks  = 0;
  int           n_fail    = 0;
  bit           mon_en    = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // One cycle of stimulus; the model tracks occupancy and expected contents.
  task automatic step(input logic [NR_IN-1:0] mask, input logic rdy, input logic fl,
                      input logic rs);
    fetch_entry_t e;
    int           n;
    bit           acc;
    @(posedge clk);
    #1;
    cur_count = mcount;
    acc = ((int'(DEPTH) - cur_count) >= int'(NR_IN)) && !fl && !rs;
    n = 0;
    for (int k = 0; k < NR_IN; k++) begin
      e.valid          = mask[k];
      e.addr           = mask[k] ? next_addr + 32'(4 * n) : 32'($urandom);
      e.instr          = 32'($urandom);
      e.ex.valid       = 1'($urandom_range(0, 1));
      e.ex.cause       = 4'($urandom);
      e.predict.taken  = 1'($urandom_range(0, 1));
      e.predict.target = 32'($urandom);
      fetch_entry[k]   = e;
      if (mask[k]) begin
        if (acc) exp_q.push_back(e);
        n++;
      end
    end
    if (acc) next_addr = next_addr + 32'(4 * n);
    decode_ready = rdy;
    flush        = fl;
    rst          = rs;
    if (fl || rs) begin
      exp_q.delete();
      mcount = 0;
    end else begin
      mcount = cur_count + (acc ? n : 0) - ((cur_count != 0 && rdy) ? 1 : 0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", 128'(count), 128'(cur_count));
      chk("fetch_ready", 128'(fetch_ready), 128'((int'(DEPTH) - cur_count) >= int'(NR_IN)));
      chk("decode_valid", 128'(decode_valid), 128'(cur_count != 0));
      if (!decode_valid) begin
        chk("empty_entry", 128'(decode_entry), 128'(0));
      end else if (!flush && !rst) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL head: got valid entry %h expected no entry", decode_entry);
        end else begin
          chk("head", 128'(decode_entry), 128'(exp_q[0]));
          if (decode_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    step('0, 1'b0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_ready", 128'(fetch_ready), 128'(1));
    chk("rst_entry", 128'(decode_entry), 128'(0));

    // First pair, no consumption
    next_addr = 32'h8000_0000;
    step(2'b11, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pair_count", 128'(count), 128'(2));
    chk("pair_head_addr", 128'(decode_entry.addr), 128'(32'h8000_0000));
    chk("pair_ready", 128'(fetch_ready), 128'(1));

    // Compaction of a 2'b10 group
    step(2'b00, 1'b1, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0, 1'b0);
    next_addr = 32'h100;
    step(2'b10, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("compact_count", 128'(count), 128'(1));
    chk("compact_head_addr", 128'(decode_entry.addr), 128'(32'h100));

    // Fill to capacity, then offer a group that must be dropped
    step(2'b00, 1'b1, 1'b0, 1'b0);
    next_addr = 32'h1000;
    for (int i = 0; i < 4; i++) step(2'b11, 1'b0, 1'b0, 1'b0);
    step(2'b11, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_count", 128'(count), 128'(8));
    chk("full_ready", 128'(fetch_ready), 128'(0));
    step(2'b00, 1'b1, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("seven_count", 128'(count), 128'(7));
    chk("seven_ready", 128'(fetch_ready), 128'(0));

    // Simultaneous push 2 / pop 1 at count 6
    step(2'b00, 1'b1, 1'b0, 1'b0);
    step(2'b11, 1'b1, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pushpop_count", 128'(count), 128'(7));
    chk("pushpop_head_addr", 128'(decode_entry.addr), 128'(32'h100C));

    // Flush at count 5 with same-cycle push and pop, then refill
    step(2'b00, 1'b1, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0, 1'b0);
    step(2'b11, 1'b1, 1'b1, 1'b0);
    next_addr = 32'h200;
    step(2'b01, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_count", 128'(count), 128'(0));
    chk("flush_valid", 128'(decode_valid), 128'(0));
    chk("flush_entry", 128'(decode_entry), 128'(0));
    chk("flush_ready", 128'(fetch_ready), 128'(1));
    step(2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("refill_head_addr", 128'(decode_entry.addr), 128'(32'h200));

    // Sustained push-2/pop-1 across pointer wrap, throttled by fetch_ready
    step(2'b00, 1'b1, 1'b0, 1'b0);
    next_addr = 32'h4000;
    for (int i = 0; i < 40; i++) step(2'b11, 1'b1, 1'b0, 1'b0);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 300; i++) begin
      step(NR_IN'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 99) == 0));
    end

    for (int i = 0; i < 20 && mcount != 0; i++) step('0, 1'b1, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("drain_scoreboard", 128'(exp_q.size()), 128'(0));
    chk("drain_count", 128'(count), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
